// File: rtl/parking_pkg.sv
// Shared types for the parking controller exit path:
// FSM states, response error codes and default widths.
package parking_pkg;

  localparam int SLOT_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    RESP,
    LOCKOUT
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_EMPTY = 2'b10
  } err_e;

endpackage

// File: rtl/lockout_timer.sv
// Down-counter that times the bad-token lockout window.
// Loads LOCK_CYCLES-1 on start; done while the count is zero.
module lockout_timer #(
  parameter int LOCK_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  output logic o_done
);

  localparam int CW =
    (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(LOCK_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/exit_token_decoder.sv
// Exit-path token decoder: recovers slot = token ^ pattern,
// validates it, answers with a handshake and locks out bad tokens.
module exit_token_decoder
  import parking_pkg::*;
#(
  parameter int SLOT_W      = SLOT_W_DEF,
  parameter int NUM_SLOTS   = 8,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16,
  parameter logic [SLOT_W-1:0] PATTERN_RST = SLOT_W'(3'b101)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pattern_load,
  input  logic [SLOT_W-1:0]    i_pattern_in,
  input  logic                 i_exit_valid,
  output logic                 o_exit_ready,
  input  logic [SLOT_W-1:0]    i_token,
  input  logic [NUM_SLOTS-1:0] i_occupied,
  output logic                 o_resp_valid,
  input  logic                 i_resp_ready,
  output logic [SLOT_W-1:0]    o_park_number,
  output logic [1:0]           o_resp_err,
  output logic [NUM_SLOTS-1:0] o_release,
  output logic                 o_locked
);

  localparam int SPAN = 1 << SLOT_W;
  localparam int FW   = $clog2(MAX_TRIES + 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_TRIES);

  state_e                 r_state;
  logic [SLOT_W-1:0]      r_pattern;
  logic [SLOT_W-1:0]      r_slot;
  logic [SLOT_W-1:0]      r_park;
  err_e                   r_err;
  logic [FW-1:0]          r_fail;
  logic                   r_exit_ready;
  logic                   r_resp_valid;
  logic [NUM_SLOTS-1:0]   r_release;
  logic                   r_locked;

  logic [SPAN-1:0]        w_occ;
  logic                   w_in_range;
  err_e                   w_err;
  logic [NUM_SLOTS-1:0]   w_onehot;
  logic                   w_lock_start;
  logic                   w_lock_done;

  // Pad the map so an out-of-range slot never indexes past it.
  assign w_occ      = SPAN'(i_occupied);
  assign w_in_range = (32'(r_slot) < NUM_SLOTS);
  assign w_onehot   = w_in_range ?
                      (NUM_SLOTS'(1) << r_slot) : '0;

  always_comb begin
    w_err = ERR_OK;
    if (!w_in_range) begin
      w_err = ERR_RANGE;
    end else if (!w_occ[r_slot]) begin
      w_err = ERR_EMPTY;
    end
  end

  assign w_lock_start = (r_state == RESP) &&
                        i_resp_ready &&
                        (r_fail == FAIL_MAX);

  lockout_timer #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lockout_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_lock_start),
    .o_done  (w_lock_done)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_pattern    <= PATTERN_RST;
      r_slot       <= '0;
      r_park       <= '0;
      r_err        <= ERR_OK;
      r_fail       <= '0;
      r_exit_ready <= 1'b0;
      r_resp_valid <= 1'b0;
      r_release    <= '0;
      r_locked     <= 1'b0;
    end else begin
      if (i_pattern_load) begin
        r_pattern <= i_pattern_in;
      end
      r_release <= '0;
      unique case (r_state)
        IDLE: begin
          if (i_exit_valid && r_exit_ready) begin
            r_slot       <= i_token ^ r_pattern;
            r_exit_ready <= 1'b0;
            r_state      <= DECODE;
          end else begin
            r_exit_ready <= 1'b1;
          end
        end
        DECODE: begin
          r_park       <= r_slot;
          r_err        <= w_err;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
          if (w_err == ERR_OK) begin
            r_release <= w_onehot;
            r_fail    <= '0;
          end else if (r_fail != FAIL_MAX) begin
            r_fail <= r_fail + 1'b1;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_park       <= '0;
            r_err        <= ERR_OK;
            if (r_fail == FAIL_MAX) begin
              r_locked <= 1'b1;
              r_state  <= LOCKOUT;
            end else begin
              r_exit_ready <= 1'b1;
              r_state      <= IDLE;
            end
          end
        end
        LOCKOUT: begin
          if (w_lock_done) begin
            r_locked     <= 1'b0;
            r_fail       <= '0;
            r_exit_ready <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_exit_ready  = r_exit_ready;
  assign o_resp_valid  = r_resp_valid;
  assign o_park_number = r_park;
  assign o_resp_err    = r_err;
  assign o_release     = r_release;
  assign o_locked      = r_locked;

endmodule
